seq11011_scan_ctrl: RTL and testbench

Scan controller that shares one embedded Moore "11011" non-overlapping sequence detector between two requesters. Each requester hands over a W-bit word. The controller arbitrates round-robin, serializes the granted word MSB-first into the detector, counts detections and reports the result with a one-cycle done pulse. It sits between word-oriented producers and the bit-serial FSM detector datapath.

---
 rtl/seq11011_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seq11011_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq11011_scan_ctrl.sv
// Round-robin scan controller: serializes a granted word MSB-first into an embedded
// Moore "11011" non-overlapping detector, counts matches and pulses done.
module seq11011_scan_ctrl #(
  parameter int W  = 16,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [W-1:0]  data0,
  input  logic          req1,
  input  logic [W-1:0]  data1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          busy,
  output logic          ser_bit,
  output logic          d,
  output logic          done,
  output logic          owner,
  output logic [CW-1:0] count
);

  localparam int BW = $clog2(W + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [2:0] S0 = 3'd0;
  localparam logic [2:0] S1 = 3'd1;
  localparam logic [2:0] S2 = 3'd2;
  localparam logic [2:0] S3 = 3'd3;
  localparam logic [2:0] S4 = 3'd4;
  localparam logic [2:0] S5 = 3'd5;

  logic [1:0]    state;
  logic [2:0]    det_state;
  logic [2:0]    det_next;
  logic [W-1:0]  shreg;
  logic [BW-1:0] bit_cnt;
  logic          last_served;
  logic          any_req;
  logic          pick1;

  // Requester 1 wins when alone, or when both ask and requester 0 was served last.
  always_comb begin
    any_req = req0 | req1;
    pick1   = req1 & (~req0 | ~last_served);
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    det_next = S0;
    case (det_state)
      S0:      det_next = ser_bit ? S1 : S0;
      S1:      det_next = ser_bit ? S2 : S0;
      S2:      det_next = ser_bit ? S2 : S3;
      S3:      det_next = ser_bit ? S4 : S0;
      S4:      det_next = ser_bit ? S5 : S0;
      S5:      det_next = ser_bit ? S1 : S0;
      default: det_next = S0;
    endcase
  end

  assign ser_bit = (state == ST_SHIFT) ? shreg[W-1] : 1'b0;
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);
  assign d       = (det_state == S5);

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      det_state   <= S0;
      shreg       <= '0;
      bit_cnt     <= '0;
      last_served <= 1'b1;
      owner       <= 1'b0;
      count       <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            shreg       <= pick1 ? data1 : data0;
            owner       <= pick1;
            last_served <= pick1;
            count       <= '0;
            bit_cnt     <= '0;
            det_state   <= S0;
            gnt0        <= ~pick1;
            gnt1        <= pick1;
            state       <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          det_state <= det_next;
          shreg     <= {shreg[W-2:0], 1'b0};
          bit_cnt   <= bit_cnt + BW'(1);
          // Count saturates instead of wrapping.
          if (det_next == S5 && count != {CW{1'b1}})
            count <= count + CW'(1);
          if (bit_cnt == BW'(W - 1))
            state <= ST_DONE;
        end
        ST_DONE: begin
          state     <= ST_IDLE;
          det_state <= S0;
        end
        default: begin
          state     <= ST_IDLE;
          det_state <= S0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq11011_scan_ctrl.sv
// Self-checking bench for seq11011_scan_ctrl: vector table, hand sequences and
// randomized scans against a pattern-matching reference model.
module tb_seq11011_scan_ctrl;

  localparam int W      = 16;
  localparam int CW     = 4;
  localparam int PERIOD = 10;

  logic          clk;
  logic          rst;
  logic          req0;
  logic [W-1:0]  data0;
  logic          req1;
  logic [W-1:0]  data1;
  logic          gnt0;
  logic          gnt1;
  logic          busy;
  logic          ser_bit;
  logic          d;
  logic          done;
  logic          owner;
  logic [CW-1:0] count;

  int   checks;
  int   errors;
  logic last_ptr;

  seq11011_scan_ctrl #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .ser_bit(ser_bit),
    .d(d), .done(done), .owner(owner), .count(count)
  );

  initial clk = 1'b0;
  always #(PERIOD / 2) clk = ~clk;

  typedef struct {
    logic         r0;
    logic         r1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic         exp_owner;
    int           exp_count;
    int           exp_pulses;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: greedy left-to-right search for non-overlapping "11011" in MSB-first
  // order. ends[j] marks that the j-th presented bit completes a match.
  task automatic model(input logic [W-1:0] w, output int cnt, output logic [W-1:0] ends);
    int j;
    logic [4:0] win;
    cnt  = 0;
    ends = '0;
    j    = 0;
    while (j <= W - 5) begin
      win = w[W-1-j -: 5];
      if (win == 5'b11011) begin
        cnt++;
        ends[j+4] = 1'b1;
        j += 5;
      end else begin
        j++;
      end
    end
    if (cnt > (1 << CW) - 1) cnt = (1 << CW) - 1;
  endtask

  task automatic zero_outputs(input string name);
    check(name, {gnt0, gnt1, busy, ser_bit, d, done, owner, count}, 0);
  endtask

  task automatic do_reset();
    rst  = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    zero_outputs("reset_outputs");
    rst      = 1'b1;
    last_ptr = 1'b1;
  endtask

  // Issues a request pattern, waits for the grant and checks the full scan.
  // Returns in the cycle after done (IDLE), at a falling edge.
  task automatic do_scan(input logic r0, input logic r1, input logic [W-1:0] d0,
                         input logic [W-1:0] d1, input bit hold, output logic obs_owner,
                         output int obs_count, output int obs_pulses, output time done_t);
    logic         win;
    logic [W-1:0] word;
    logic [W-1:0] ends;
    int           exp_cnt;
    bit           got;
    win  = (r0 && r1) ? ~last_ptr : r1;
    word = win ? d1 : d0;
    model(word, exp_cnt, ends);
    req0 = r0; req1 = r1; data0 = d0; data1 = d1;
    obs_owner = 1'b0; obs_count = 0; obs_pulses = 0; done_t = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = gnt0 | gnt1;
    end
    check("grant_seen", {31'd0, got}, 1);
    if (!got) return;
    last_ptr = win;
    check("gnt_pair", {gnt1, gnt0}, win ? 2 : 1);
    check("owner_at_grant", owner, win);
    check("count_cleared", count, 0);
    if (!hold) begin
      if (win) req1 = 1'b0;
      else     req0 = 1'b0;
    end
    for (int k = 0; k < W; k++) begin
      check("ser_bit", ser_bit, word[W-1-k]);
      check("busy_shift", busy, 1);
      check("done_early", done, 0);
      check("d_shift", d, (k > 0) ? ends[k-1] : 1'b0);
      if (k == 1) check("gnt_one_cycle", {gnt1, gnt0}, 0);
      obs_pulses += int'(d);
      @(negedge clk);
    end
    check("done_pulse", done, 1);
    check("d_done_cycle", d, ends[W-1]);
    check("count_final", count, exp_cnt);
    check("owner_final", owner, win);
    check("busy_done", busy, 1);
    check("ser_bit_done", ser_bit, 0);
    obs_pulses += int'(d);
    obs_owner = owner;
    obs_count = int'(count);
    done_t    = $time;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_idle", busy, 0);
    check("count_hold", count, exp_cnt);
    check("gnt_idle", {gnt1, gnt0}, 0);
  endtask

  function automatic logic [W-1:0] make_word();
    logic [W-1:0] w;
    w = W'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 2) == 0) w = {w[W-6:0], 5'b11011};
        else                           w = {w[W-3:0], 2'($urandom)};
      end
    end
    return w;
  endfunction

  initial begin
    vec_t         vecs[4];
    logic         o_own;
    int           o_cnt;
    int           o_pul;
    time          t_done;
    time          t_prev;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    logic         r0;
    logic         r1;
    logic [3:0]   exp_order;
    int           n;
    bit           got;

    checks = 0; errors = 0;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0; last_ptr = 1'b1;

    vecs[0] = '{r0: 1'b1, r1: 1'b0, d0: 16'hDEF6, d1: 16'h0000, exp_owner: 1'b0, exp_count: 3, exp_pulses: 3};
    vecs[1] = '{r0: 1'b0, r1: 1'b1, d0: 16'h0000, d1: 16'hDB00, exp_owner: 1'b1, exp_count: 1, exp_pulses: 1};
    vecs[2] = '{r0: 1'b1, r1: 1'b0, d0: 16'h001B, d1: 16'h0000, exp_owner: 1'b0, exp_count: 1, exp_pulses: 1};
    vecs[3] = '{r0: 1'b1, r1: 1'b0, d0: 16'h0000, d1: 16'hFFFF, exp_owner: 1'b0, exp_count: 0, exp_pulses: 0};

    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_scan(vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1, 1'b0, o_own, o_cnt, o_pul, t_done);
      check("vec_owner", o_own, vecs[i].exp_owner);
      check("vec_count", o_cnt, vecs[i].exp_count);
      check("vec_d_pulses", o_pul, vecs[i].exp_pulses);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Both requesters held from reset: strict alternation, one grant every W+2 cycles.
    do_reset();
    exp_order = 4'b1010;
    t_prev = 0;
    for (int i = 0; i < 4; i++) begin
      do_scan(1'b1, 1'b1, 16'hDEF6, 16'hDB00, 1'b1, o_own, o_cnt, o_pul, t_done);
      check("rr_owner", o_own, exp_order[i]);
      check("rr_count", o_cnt, exp_order[i] ? 1 : 3);
      if (i > 0) check("rr_done_spacing", 32'(t_done - t_prev), (W + 2) * PERIOD);
      t_prev = t_done;
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the middle of a scan aborts it without a done pulse.
    do_reset();
    req0 = 1'b1; data0 = 16'hDEF6;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = gnt0;
    end
    check("abort_grant_seen", {31'd0, got}, 1);
    repeat (8) @(negedge clk);
    check("abort_bit7", ser_bit, 1);
    check("abort_count_before", count, 1);
    rst = 1'b0;
    #1;
    zero_outputs("abort_outputs");
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n += int'(done) + int'(busy);
    end
    check("abort_quiet", n, 0);
    rst = 1'b1;
    last_ptr = 1'b1;
    do_scan(1'b1, 1'b0, 16'hDEF6, 16'h0000, 1'b0, o_own, o_cnt, o_pul, t_done);
    check("regrant_count", o_cnt, 3);
    check("regrant_owner", o_own, 0);
    req0 = 1'b0;

    // Randomized requests and words checked against the reference model.
    for (int i = 0; i < 24; i++) begin
      n  = $urandom_range(1, 3);
      r0 = n[0];
      r1 = n[1];
      w0 = make_word();
      w1 = make_word();
      do_scan(r0, r1, w0, w1, 1'b0, o_own, o_cnt, o_pul, t_done);
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
